// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//
// Purpose:
//   Shared definitions for the instruction fetch front end and its helpers.
//   It holds the fetch FSM state encoding, the instruction-word value used as
//   a pipeline bubble, and the size of one instruction in bytes.
//
// Contents:
//   fetch_state_t  - IDLE / FETCH / HOLD / DRAIN
//   BUBBLE_INST    - all-zero word; the same value an IF/ID flush produces
//   INST_BYTES     - PC stride between consecutive instructions
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // Fetch front-end states:
    //   IDLE  - waiting for the run enable, no memory traffic
    //   FETCH - a request is on the bus for pc_q
    //   HOLD  - a fetched word is parked in the skid buffer during a stall
    //   DRAIN - an abandoned request is being completed after a redirect
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // The bubble is an all-zero word so that a fetch-side bubble looks the
    // same to decode as a flushed IF/ID register.
    localparam logic [31:0] BUBBLE_INST = 32'b0;

    // Every instruction is one 32-bit word.
    localparam int unsigned INST_BYTES = 4;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
//
// Purpose:
//   Single-entry holding register for one fetched {pc, instruction} pair.
//   The fetch unit parks a word here when memory acknowledges in a cycle
//   where the downstream stage is stalled. Without it, the word would have to
//   be fetched again, which would duplicate a memory access.
//
// Ports:
//   i_clk    - clock, all updates on the rising edge
//   i_rst    - synchronous active-high reset, empties the entry
//   i_load   - capture i_pc / i_inst and mark the entry full
//   i_clear  - empty the entry (wins over i_load)
//   i_pc     - PC of the word being parked
//   i_inst   - instruction word being parked
//   o_pc     - parked PC
//   o_inst   - parked instruction word
//   o_full   - entry holds a real instruction
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst,
    output logic            o_full
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_full;

    // Storage for the single parked entry. A clear empties the entry and
    // also returns the data to the bubble value, so a stale word can never
    // leak out even if someone reads the data without checking the flag.
    // Clear wins over load because a redirect that arrives in the same cycle
    // as a stalled ack has to throw the acked word away.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_pc   <= '0;
            r_inst <= XLEN'(BUBBLE_INST);
            r_full <= 1'b0;
        end else if (i_load) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
            r_full <= 1'b1;
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;
    assign o_full = r_full;

endmodule : fetch_skid_buf

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose:
//   Instruction fetch front end. It owns the program counter and fetches
//   words from instruction memory over a req/ack handshake. It writes
//   {PC, instruction, valid} into the IF/ID boundary and obeys the same stall
//   and flush (redirect) controls that the IF/ID register receives from the
//   hazard unit. Multi-cycle memory, redirects and backpressure are handled
//   so that no instruction is lost or delivered twice.
//
// Parameters:
//   XLEN      - width of PC and instruction words
//   RESET_PC  - PC loaded at reset
//
// Ports:
//   clk_i          - clock
//   rst_i          - synchronous active-high reset
//   start_i        - run enable, only looked at while IDLE
//   stall_i        - downstream stall, delivered outputs must hold
//   redirect_i     - branch taken / flush
//   redirect_pc_i  - new fetch address (low two bits ignored)
//   imem_req_o     - memory request
//   imem_addr_o    - memory request address
//   imem_ack_i     - single-cycle data-valid strobe from memory
//   imem_rdata_i   - instruction word, meaningful while imem_ack_i=1
//   PC_o           - PC of the delivered instruction
//   instruction_o  - delivered instruction
//   inst_valid_o   - delivered pair is a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] PC_o,
    output logic [XLEN-1:0] instruction_o,
    output logic            inst_valid_o
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] BUBBLE    = XLEN'(BUBBLE_INST);
    localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

    // Architectural state of the front end.
    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_drainAddr;
    logic [XLEN-1:0] r_pcOut;
    logic [XLEN-1:0] r_instOut;
    logic            r_validOut;

    // Next-state values computed by the combinational process.
    fetch_state_t    w_nextState;
    logic [XLEN-1:0] w_nextPc;
    logic [XLEN-1:0] w_nextDrainAddr;
    logic [XLEN-1:0] w_nextPcOut;
    logic [XLEN-1:0] w_nextInstOut;
    logic            w_nextValidOut;

    // Skid buffer control and read-back.
    logic            w_skidLoad;
    logic            w_skidClear;
    logic [XLEN-1:0] w_skidPc;
    logic [XLEN-1:0] w_skidInst;
    logic            w_skidFull;

    // Helper terms.
    logic            w_reqActive;
    logic [XLEN-1:0] w_pcPlus;
    logic [XLEN-1:0] w_redirectTarget;

    // Single parked word used when memory answers during a stall.
    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_pc    (r_pc),
        .i_inst  (imem_rdata_i),
        .o_pc    (w_skidPc),
        .o_inst  (w_skidInst),
        .o_full  (w_skidFull)
    );

    // A request is on the bus in FETCH (for the current pc) and in DRAIN (for
    // the address that was outstanding when a redirect arrived). DRAIN needs
    // its own copy of the address because the redirect has already replaced
    // pc_q, yet the memory expects the address to stay put until it acks.
    // The PC increment wraps naturally at 2^XLEN, and redirect targets are
    // forced to word alignment.
    always_comb begin
        w_reqActive      = (r_state == FETCH) || (r_state == DRAIN);
        w_pcPlus         = r_pc + PC_STEP;
        w_redirectTarget = redirect_pc_i & ALIGN_MSK;
    end

    assign imem_req_o    = w_reqActive;
    assign imem_addr_o   = (r_state == DRAIN) ? r_drainAddr : r_pc;
    assign PC_o          = r_pcOut;
    assign instruction_o = r_instOut;
    assign inst_valid_o  = r_validOut;

    // Next-state and output-register logic for the fetch FSM.
    //
    // A redirect is handled first and overrides everything else: the target
    // becomes the new pc_q, the delivered pair turns into a bubble even while
    // stalled (the instruction is on the wrong path), and any parked word is
    // dropped. If a request is still open without an ack, the bus must keep
    // the old address until memory answers, so the FSM goes to DRAIN and
    // throws that answer away. Otherwise fetching restarts at the target on
    // the next cycle. In IDLE a redirect only moves pc_q.
    //
    // Without a redirect:
    //   FETCH with ack and no stall delivers the word and advances pc_q.
    //   FETCH with ack under stall cannot overwrite the held outputs, so the
    //   word is parked in the skid buffer and pc_q still advances. This way
    //   the word is neither refetched nor lost.
    //   FETCH without ack emits a bubble once downstream has taken the
    //   current pair, and holds the outputs while stalled.
    //   HOLD stays off the bus and releases the parked word when the stall
    //   clears.
    //   DRAIN waits for the stale ack and then resumes at pc_q.
    always_comb begin
        w_nextState     = r_state;
        w_nextPc        = r_pc;
        w_nextDrainAddr = r_drainAddr;
        w_nextPcOut     = r_pcOut;
        w_nextInstOut   = r_instOut;
        w_nextValidOut  = r_validOut;
        w_skidLoad      = 1'b0;
        w_skidClear     = 1'b0;

        if (redirect_i) begin
            w_nextPc = w_redirectTarget;
            if (r_state != IDLE) begin
                w_nextPcOut    = '0;
                w_nextInstOut  = BUBBLE;
                w_nextValidOut = 1'b0;
                w_skidClear    = 1'b1;
                if (w_reqActive && !imem_ack_i) begin
                    w_nextState = DRAIN;
                    if (r_state == FETCH) begin
                        w_nextDrainAddr = r_pc;
                    end
                end else begin
                    w_nextState = FETCH;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_nextState = FETCH;
                    end
                end

                FETCH: begin
                    if (imem_ack_i) begin
                        w_nextPc = w_pcPlus;
                        if (stall_i) begin
                            w_skidLoad  = 1'b1;
                            w_nextState = HOLD;
                        end else begin
                            w_nextPcOut    = r_pc;
                            w_nextInstOut  = imem_rdata_i;
                            w_nextValidOut = 1'b1;
                        end
                    end else if (!stall_i) begin
                        w_nextPcOut    = '0;
                        w_nextInstOut  = BUBBLE;
                        w_nextValidOut = 1'b0;
                    end
                end

                HOLD: begin
                    if (!stall_i) begin
                        w_nextPcOut    = w_skidPc;
                        w_nextInstOut  = w_skidInst;
                        w_nextValidOut = w_skidFull;
                        w_skidClear    = 1'b1;
                        w_nextState    = FETCH;
                    end
                end

                DRAIN: begin
                    w_nextPcOut    = '0;
                    w_nextInstOut  = BUBBLE;
                    w_nextValidOut = 1'b0;
                    if (imem_ack_i) begin
                        w_nextState = FETCH;
                    end
                end

                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State register. Reset is synchronous and beats every other action,
    // including a half-finished memory transaction. The memory is reset along
    // with this block, so an abandoned request needs no cleanup here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_drainAddr <= '0;
            r_pcOut     <= '0;
            r_instOut   <= BUBBLE;
            r_validOut  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pc        <= w_nextPc;
            r_drainAddr <= w_nextDrainAddr;
            r_pcOut     <= w_nextPcOut;
            r_instOut   <= w_nextInstOut;
            r_validOut  <= w_nextValidOut;
        end
    end

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Purpose:
//   Self-checking bench for if_fetch_unit. A small instruction memory model
//   has a programmable number of wait states, and each word is its address
//   XOR 32'h1300_0013. Directed scenarios push the expected delivered
//   instructions and expected memory accesses into queues. A monitor pops
//   and compares whenever the DUT delivers an instruction to an unstalled
//   consumer, or when memory acks a request.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] PC_o;
    logic [31:0] instruction_o;
    logic        inst_valid_o;

    int checks;
    int failures;
    int waitStates;
    int waitCnt;

    item_t       dataQ[$];
    logic [31:0] addrQ[$];

    if_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .PC_o          (PC_o),
        .instruction_o (instruction_o),
        .inst_valid_o  (inst_valid_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h1300_0013;
    endfunction

    // Memory model: it acks once the request has been open for waitStates
    // cycles, and it is reset together with the DUT.
    always_comb begin
        imem_ack_i   = imem_req_o && (waitCnt >= waitStates);
        imem_rdata_i = memWord(imem_addr_o);
    end

    // Counts how many cycles the current request has been open without an
    // ack; this drives the memory model's wait states.
    always @(posedge clk_i) begin
        if (rst_i || !imem_req_o || imem_ack_i) begin
            waitCnt <= 0;
        end else begin
            waitCnt <= waitCnt + 1;
        end
    end

    // Compares an actual value with the expected one and records the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives all non-reset inputs for one rising edge, then returns 1 time
    // unit after that edge so the caller can sample the new register values.
    task automatic applyStimulus(input logic start, input logic stall,
                                 input logic redirect, input logic [31:0] rpc);
        start_i       = start;
        stall_i       = stall;
        redirect_i    = redirect;
        redirect_pc_i = rpc;
        @(posedge clk_i);
        #1;
    endtask

    // Pushes n sequential instructions starting at base, wrapping at 2^32.
    task automatic pushData(input logic [31:0] base, input int n);
        logic [31:0] pc;
        pc = base;
        for (int i = 0; i < n; i++) begin
            dataQ.push_back({pc, memWord(pc)});
            pc = pc + 32'd4;
        end
    endtask

    // Pushes n sequential expected request addresses starting at base.
    task automatic pushAddr(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            addrQ.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Holds reset for two edges and discards any leftover expectations.
    task automatic resetDut();
        rst_i      = 1'b1;
        waitStates = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        dataQ.delete();
        addrQ.delete();
        rst_i = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge. An instruction counts
    // as consumed when it is valid and downstream is not stalled; every
    // memory ack must match the next expected address.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (imem_req_o && imem_ack_i) begin
                if (addrQ.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("[TB] FAIL ack_unexpected: got addr 0x%08h, expected none", imem_addr_o);
                end else begin
                    checkOutput("ack_addr", imem_addr_o, addrQ.pop_front());
                end
            end
            if (inst_valid_o && !stall_i) begin
                if (dataQ.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("[TB] FAIL deliver_unexpected: got pc 0x%08h, expected none", PC_o);
                end else begin
                    item_t exp;
                    exp = dataQ.pop_front();
                    checkOutput("deliver_pc", PC_o, exp.pc);
                    checkOutput("deliver_inst", instruction_o, exp.inst);
                end
            end
        end
    end

    // Global time limit, so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        checks        = 0;
        failures      = 0;
        waitStates    = 0;
        rst_i         = 1'b1;
        start_i       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;

        // Reset state, then zero-wait streaming.
        resetDut();
        checkOutput("rst_pc", PC_o, 32'h0);
        checkOutput("rst_inst", instruction_o, 32'h0);
        checkOutput("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        checkOutput("rst_req", {31'b0, imem_req_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("idle_req", {31'b0, imem_req_o}, 32'h0);
        pushData(32'h0, 16);
        pushAddr(32'h0, 16);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("zw_req0", {31'b0, imem_req_o}, 32'h1);
        checkOutput("zw_addr0", imem_addr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("zw_addr4", imem_addr_o, 32'h4);
        checkOutput("zw_pc0", PC_o, 32'h0);
        checkOutput("zw_inst0", instruction_o, 32'h1300_0013);
        checkOutput("zw_valid0", {31'b0, inst_valid_o}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("zw_addr8", imem_addr_o, 32'h8);
        checkOutput("zw_pc4", PC_o, 32'h4);
        checkOutput("zw_inst4", instruction_o, 32'h1300_0017);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("zw_pc8", PC_o, 32'h8);
        checkOutput("zw_inst8", instruction_o, 32'h1300_001B);

        // One wait state per fetch: valid alternates 0/1.
        resetDut();
        waitStates = 1;
        pushData(32'h0, 16);
        pushAddr(32'h0, 16);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("ws_valid", {31'b0, inst_valid_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (i % 2 == 0) begin
                checkOutput("ws_pc", PC_o, 32'((i / 2 - 1) * 4));
            end
        end

        // Stall on the ack cycle of address 8, held for three cycles.
        resetDut();
        pushData(32'h0, 16);
        pushAddr(32'h0, 16);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("stall_pc_hold", PC_o, 32'h4);
            checkOutput("stall_req_off", {31'b0, imem_req_o}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("unstall_pc", PC_o, 32'h8);
        checkOutput("unstall_valid", {31'b0, inst_valid_o}, 32'h1);
        checkOutput("unstall_addr", imem_addr_o, 32'hC);

        // Redirect to 0x100 while address 12 is outstanding without ack.
        resetDut();
        pushData(32'h0, 3);
        pushData(32'h100, 13);
        pushAddr(32'h0, 4);
        pushAddr(32'h100, 12);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_addr12", imem_addr_o, 32'hC);
        waitStates = 3;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        checkOutput("rd_drain_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("rd_drain_addr", imem_addr_o, 32'hC);
        checkOutput("rd_bubble", {31'b0, inst_valid_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_drain_addr2", imem_addr_o, 32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_drain_ack", {31'b0, imem_ack_i}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_new_addr", imem_addr_o, 32'h100);
        waitStates = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_first_pc", PC_o, 32'h100);
        checkOutput("rd_first_inst", instruction_o, 32'h1300_0113);
        checkOutput("rd_first_valid", {31'b0, inst_valid_o}, 32'h1);

        // Redirect and stall together, with an ack in the same cycle.
        resetDut();
        pushData(32'h0, 1);
        pushData(32'h200, 15);
        pushAddr(32'h0, 3);
        pushAddr(32'h200, 13);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        checkOutput("rs_pc", PC_o, 32'h0);
        checkOutput("rs_inst", instruction_o, 32'h0);
        checkOutput("rs_valid", {31'b0, inst_valid_o}, 32'h0);
        checkOutput("rs_addr", imem_addr_o, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rs_pc_target", PC_o, 32'h200);
        checkOutput("rs_valid_target", {31'b0, inst_valid_o}, 32'h1);

        // Unaligned redirect near the top of memory, wraparound, a second
        // redirect while draining, then reset in the middle of DRAIN.
        resetDut();
        pushData(32'hFFFF_FFFC, 16);
        pushAddr(32'h0, 1);
        pushAddr(32'hFFFF_FFFC, 15);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        checkOutput("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        checkOutput("wrap_bubble", {31'b0, inst_valid_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pc_top", PC_o, 32'hFFFF_FFFC);
        checkOutput("wrap_inst_top", instruction_o, 32'hECFF_FFEF);
        checkOutput("wrap_addr_zero", imem_addr_o, 32'h0);
        waitStates = 3;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("drain_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("drain_addr", imem_addr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
        checkOutput("drain_rd2_addr", imem_addr_o, 32'h0);
        checkOutput("drain_rd2_valid", {31'b0, inst_valid_o}, 32'h0);
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("drain_rst_pc", PC_o, 32'h0);
        checkOutput("drain_rst_inst", instruction_o, 32'h0);
        checkOutput("drain_rst_valid", {31'b0, inst_valid_o}, 32'h0);
        checkOutput("drain_rst_req", {31'b0, imem_req_o}, 32'h0);
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("post_rst_idle_req", {31'b0, imem_req_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_unit
